pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the eCPU 5-stage core (IF/ID/EX/MEM/WB). It drives the execute stage's operand forwarding selects, inserts load-use bubbles, sequences branch/jump flushes with a registered fetch redirect, and freezes the pipeline while the data-memory port is busy. It also keeps stall and flush performance counters. It sits beside the datapath and connects to every stage's stall and flush inputs.

---
 rtl/pipe_hazard_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- central hazard controller for the eCPU 5-stage core.
//
// Computes EX-stage operand forwarding selects, inserts load-use bubbles,
// sequences branch/jump flushes with a registered fetch redirect, freezes the
// pipe while the data-memory port is busy, and keeps stall/flush counters.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   id_*  / ex_* / mem_* / wb_*   per-stage valid, register addresses, control
//   branch_taken_i, branch_target_i   control-flow decision from execute
//   dmem_busy_i              data memory still working this cycle
//   clear_cnt_i              synchronous clear of both counters
//   forward_a_o/forward_b_o  00 none, 01 from MEM, 10 from WB
//   stall_{if,id,ex,mem}_o   hold the stage's pipeline register
//   flush_{id,ex}_o          load a bubble into IF/ID or ID/EX
//   redirect_valid_o/pc_o    one-cycle registered fetch redirect
//   stall_cycles_o, flush_count_o   wrapping performance counters

// One forwarding mux select per EX source operand.
module hc_fwd_sel #(
  parameter int RAW = 5
) (
  input  logic [RAW-1:0] rs_i,
  input  logic           mem_en_i,
  input  logic [RAW-1:0] mem_rd_i,
  input  logic           wb_en_i,
  input  logic [RAW-1:0] wb_rd_i,
  output logic [1:0]     sel_o
);
  always_comb begin
    sel_o = 2'b00;
    if (mem_en_i && (mem_rd_i == rs_i))     sel_o = 2'b01;
    else if (wb_en_i && (wb_rd_i == rs_i))  sel_o = 2'b10;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      id_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                      ex_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic                      ex_reg_write_i,
  input  logic                      ex_mem_read_i,
  input  logic                      mem_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr_i,
  input  logic                      mem_reg_write_i,
  input  logic                      mem_mem_read_i,
  input  logic                      wb_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_i,
  input  logic                      wb_reg_write_i,
  input  logic                      branch_taken_i,
  input  logic [ADDR_WIDTH-1:0]     branch_target_i,
  input  logic                      dmem_busy_i,
  input  logic                      clear_cnt_i,
  output logic [1:0]                forward_a_o,
  output logic [1:0]                forward_b_o,
  output logic                      stall_if_o,
  output logic                      stall_id_o,
  output logic                      stall_ex_o,
  output logic                      stall_mem_o,
  output logic                      flush_id_o,
  output logic                      flush_ex_o,
  output logic                      redirect_valid_o,
  output logic [ADDR_WIDTH-1:0]     redirect_pc_o,
  output logic [XLEN-1:0]           stall_cycles_o,
  output logic [XLEN-1:0]           flush_count_o
);
  localparam int RAW  = REG_ADDR_WIDTH;
  localparam int NOPS = 2;

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, LU_STALL} state_e;

  state_e                 state_q, state_d;
  logic                   redir_vld_q;
  logic [ADDR_WIDTH-1:0]  redir_pc_q;
  logic [XLEN-1:0]        stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0]        flush_cnt_q, flush_cnt_d;
  logic                   accept;
  logic                   lu;

  // EX writes a register only matters for forwarding once it reaches MEM/WB.
  logic unused_ex_reg_write;
  assign unused_ex_reg_write = ex_reg_write_i;

  // ---------------- forwarding ----------------
  // A load in MEM has no data yet; load-use stalling covers that case.
  logic                          mem_fwd_en, wb_fwd_en;
  logic [NOPS-1:0][RAW-1:0]      ex_rs;
  logic [NOPS-1:0][1:0]          fwd_sel;

  assign mem_fwd_en = mem_valid_i && mem_reg_write_i && !mem_mem_read_i &&
                      (mem_rd_addr_i != '0);
  assign wb_fwd_en  = wb_valid_i && wb_reg_write_i && (wb_rd_addr_i != '0);
  assign ex_rs[0]   = ex_rs1_addr_i;
  assign ex_rs[1]   = ex_rs2_addr_i;

  for (genvar g = 0; g < NOPS; g++) begin : g_fwd
    hc_fwd_sel #(.RAW(RAW)) u_sel (
      .rs_i     (ex_rs[g]),
      .mem_en_i (mem_fwd_en),
      .mem_rd_i (mem_rd_addr_i),
      .wb_en_i  (wb_fwd_en),
      .wb_rd_i  (wb_rd_addr_i),
      .sel_o    (fwd_sel[g])
    );
  end

  assign forward_a_o = fwd_sel[0];
  assign forward_b_o = fwd_sel[1];

  // ---------------- hazard FSM ----------------
  assign lu = ex_valid_i && ex_mem_read_i && (ex_rd_addr_i != '0) && id_valid_i &&
              ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  // Priority: busy > accepted branch > FLUSH cycle > load-use.
  // The load-use check also applies in the cycle busy drops (state MEM_WAIT):
  // the dependent pair was frozen in place and still needs its bubble.
  always_comb begin
    state_d     = RUN;
    accept      = 1'b0;
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    if (dmem_busy_i) begin
      stall_if_o  = 1'b1;
      stall_id_o  = 1'b1;
      stall_ex_o  = 1'b1;
      stall_mem_o = 1'b1;
      state_d     = MEM_WAIT;
    end else if (branch_taken_i && (state_q != FLUSH)) begin
      accept     = 1'b1;
      flush_id_o = 1'b1;
      flush_ex_o = 1'b1;
      state_d    = FLUSH;
    end else if (state_q == FLUSH) begin
      // Kill the wrong-path fetch that entered while the redirect was in flight.
      flush_id_o = 1'b1;
      flush_ex_o = 1'b1;
      state_d    = RUN;
    end else if (lu) begin
      stall_if_o = 1'b1;
      stall_id_o = 1'b1;
      flush_ex_o = 1'b1;
      state_d    = LU_STALL;
    end
  end

  // ---------------- redirect ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
    end else begin
      redir_vld_q <= accept;
      if (accept) redir_pc_q <= branch_target_i;
    end
  end

  assign redirect_valid_o = redir_vld_q;
  assign redirect_pc_o    = redir_pc_q;

  // ---------------- counters ----------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clear_cnt_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_if_o) stall_cnt_d = stall_cnt_q + XLEN'(1);
      if (accept)     flush_cnt_d = flush_cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Counters are built 8 bits wide
// so the wrap can be reached by stalling.
module tb_pipe_hazard_ctrl;
  localparam int XL  = 8;
  localparam int AW  = 32;
  localparam int RAW = 5;

  typedef struct packed {
    logic           id_v;
    logic [RAW-1:0] id_rs1, id_rs2;
    logic           ex_v;
    logic [RAW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic           ex_rw, ex_mr;
    logic           mem_v;
    logic [RAW-1:0] mem_rd;
    logic           mem_rw, mem_mr;
    logic           wb_v;
    logic [RAW-1:0] wb_rd;
    logic           wb_rw;
    logic           br;
    logic [AW-1:0]  tgt;
    logic           busy, clr;
  } pin_t;

  typedef struct packed {
    pin_t       p;
    logic [1:0] fa, fb;
    logic       sif, fex;
  } vec_t;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic id_valid_i, ex_valid_i, ex_reg_write_i, ex_mem_read_i;
  logic [RAW-1:0] id_rs1_addr_i, id_rs2_addr_i, ex_rs1_addr_i, ex_rs2_addr_i, ex_rd_addr_i;
  logic mem_valid_i, mem_reg_write_i, mem_mem_read_i, wb_valid_i, wb_reg_write_i;
  logic [RAW-1:0] mem_rd_addr_i, wb_rd_addr_i;
  logic branch_taken_i, dmem_busy_i, clear_cnt_i;
  logic [AW-1:0] branch_target_i;
  logic [1:0] forward_a_o, forward_b_o;
  logic stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, flush_id_o, flush_ex_o;
  logic redirect_valid_o;
  logic [AW-1:0] redirect_pc_o;
  logic [XL-1:0] stall_cycles_o, flush_count_o;

  pipe_hazard_ctrl #(.XLEN(XL), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RAW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .ex_valid_i(ex_valid_i), .ex_rs1_addr_i(ex_rs1_addr_i), .ex_rs2_addr_i(ex_rs2_addr_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_reg_write_i(ex_reg_write_i), .ex_mem_read_i(ex_mem_read_i),
    .mem_valid_i(mem_valid_i), .mem_rd_addr_i(mem_rd_addr_i), .mem_reg_write_i(mem_reg_write_i),
    .mem_mem_read_i(mem_mem_read_i), .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i),
    .wb_reg_write_i(wb_reg_write_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i), .dmem_busy_i(dmem_busy_i), .clear_cnt_i(clear_cnt_i),
    .forward_a_o(forward_a_o), .forward_b_o(forward_b_o),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o),
    .stall_mem_o(stall_mem_o), .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;

  // Reference model: only "a FLUSH cycle is owed" matters for outputs.
  logic          m_fp, m_rv;
  logic [AW-1:0] m_rpc;
  logic [XL-1:0] m_sc, m_fc;
  logic          e_acc, e_sif;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input pin_t p);
    id_valid_i = p.id_v;  id_rs1_addr_i = p.id_rs1; id_rs2_addr_i = p.id_rs2;
    ex_valid_i = p.ex_v;  ex_rs1_addr_i = p.ex_rs1; ex_rs2_addr_i = p.ex_rs2;
    ex_rd_addr_i = p.ex_rd; ex_reg_write_i = p.ex_rw; ex_mem_read_i = p.ex_mr;
    mem_valid_i = p.mem_v; mem_rd_addr_i = p.mem_rd; mem_reg_write_i = p.mem_rw;
    mem_mem_read_i = p.mem_mr;
    wb_valid_i = p.wb_v; wb_rd_addr_i = p.wb_rd; wb_reg_write_i = p.wb_rw;
    branch_taken_i = p.br; branch_target_i = p.tgt;
    dmem_busy_i = p.busy; clear_cnt_i = p.clr;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [RAW-1:0] rs);
    if (mem_valid_i && mem_reg_write_i && !mem_mem_read_i && mem_rd_addr_i != 0 &&
        mem_rd_addr_i == rs) return 2'b01;
    if (wb_valid_i && wb_reg_write_i && wb_rd_addr_i != 0 && wb_rd_addr_i == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_check();
    logic lu, bsy, fid, fex, sid;
    lu  = ex_valid_i && ex_mem_read_i && ex_rd_addr_i != 0 && id_valid_i &&
          (ex_rd_addr_i == id_rs1_addr_i || ex_rd_addr_i == id_rs2_addr_i);
    bsy = dmem_busy_i;
    e_acc = 0; e_sif = 0; sid = 0; fid = 0; fex = 0;
    if (bsy) begin
      e_sif = 1; sid = 1;
    end else if (branch_taken_i && !m_fp) begin
      e_acc = 1; fid = 1; fex = 1;
    end else if (m_fp) begin
      fid = 1; fex = 1;
    end else if (lu) begin
      e_sif = 1; sid = 1; fex = 1;
    end
    chk("fwd_a", forward_a_o, ref_fwd(ex_rs1_addr_i));
    chk("fwd_b", forward_b_o, ref_fwd(ex_rs2_addr_i));
    chk("stall_if", stall_if_o, e_sif);
    chk("stall_id", stall_id_o, sid);
    chk("stall_ex", stall_ex_o, bsy);
    chk("stall_mem", stall_mem_o, bsy);
    chk("flush_id", flush_id_o, fid);
    chk("flush_ex", flush_ex_o, fex);
    chk("redir_vld", redirect_valid_o, m_rv);
    if (m_rv) chk("redir_pc", redirect_pc_o, m_rpc);
    chk("stall_cnt", stall_cycles_o, m_sc);
    chk("flush_cnt", flush_count_o, m_fc);
  endtask

  task automatic model_advance();
    m_sc = clear_cnt_i ? '0 : m_sc + XL'(e_sif);
    m_fc = clear_cnt_i ? '0 : m_fc + XL'(e_acc);
    m_rv = e_acc;
    if (e_acc) m_rpc = branch_target_i;
    m_fp = e_acc;
  endtask

  task automatic model_reset();
    m_fp = 0; m_rv = 0; m_rpc = '0; m_sc = '0; m_fc = '0;
  endtask

  // Entered at posedge+1; leaves at the following posedge+1.
  task automatic step();
    #4;
    model_check();
    @(posedge clk_i); #1;
    model_advance();
  endtask

  pin_t p;
  vec_t tbl[$];

  initial begin
    // ---------------- vector table ----------------
    p = '0; p.ex_rs1 = 5; p.mem_v = 1; p.mem_rd = 5; p.mem_rw = 1; p.wb_v = 1; p.wb_rd = 5; p.wb_rw = 1;
    tbl.push_back('{p, 2'b01, 2'b00, 1'b0, 1'b0});
    p.mem_mr = 1;
    tbl.push_back('{p, 2'b10, 2'b00, 1'b0, 1'b0});
    p = '0; p.mem_v = 1; p.mem_rw = 1; p.wb_v = 1; p.wb_rw = 1;
    tbl.push_back('{p, 2'b00, 2'b00, 1'b0, 1'b0});
    p = '0; p.ex_rs1 = 3; p.ex_rs2 = 9; p.wb_v = 1; p.wb_rd = 9; p.wb_rw = 1;
    tbl.push_back('{p, 2'b00, 2'b10, 1'b0, 1'b0});
    p = '0; p.ex_rs1 = 4; p.ex_rs2 = 4; p.mem_rd = 4; p.mem_rw = 1; p.wb_v = 1; p.wb_rd = 4;
    tbl.push_back('{p, 2'b00, 2'b00, 1'b0, 1'b0});
    p = '0; p.ex_rs2 = 6; p.mem_v = 1; p.mem_rd = 6; p.mem_rw = 1; p.wb_v = 1; p.wb_rd = 6; p.wb_rw = 1;
    tbl.push_back('{p, 2'b00, 2'b01, 1'b0, 1'b0});
    p = '0; p.ex_v = 1; p.ex_mr = 1; p.ex_rd = 7; p.id_v = 1; p.id_rs2 = 7;
    tbl.push_back('{p, 2'b00, 2'b00, 1'b1, 1'b1});
    p.id_rs2 = 2; p.id_rs1 = 7;
    tbl.push_back('{p, 2'b00, 2'b00, 1'b1, 1'b1});
    p.ex_rd = 0; p.id_rs1 = 0;
    tbl.push_back('{p, 2'b00, 2'b00, 1'b0, 1'b0});
    p.ex_rd = 7; p.id_rs1 = 7; p.id_v = 0;
    tbl.push_back('{p, 2'b00, 2'b00, 1'b0, 1'b0});

    // ---------------- reset ----------------
    model_reset();
    drive('0);
    @(posedge clk_i); #1;
    chk("rst_rv", redirect_valid_o, 0);
    chk("rst_pc", redirect_pc_o, 0);
    chk("rst_sc", stall_cycles_o, 0);
    chk("rst_fc", flush_count_o, 0);
    rst_ni = 1;

    // ---------------- table ----------------
    foreach (tbl[i]) begin
      drive(tbl[i].p);
      #4;
      chk($sformatf("tbl%0d_fa", i), forward_a_o, tbl[i].fa);
      chk($sformatf("tbl%0d_fb", i), forward_b_o, tbl[i].fb);
      chk($sformatf("tbl%0d_sif", i), stall_if_o, tbl[i].sif);
      chk($sformatf("tbl%0d_fex", i), flush_ex_o, tbl[i].fex);
      model_check();
      @(posedge clk_i); #1;
      model_advance();
    end

    // ---------------- load-use ----------------
    p = '0; p.clr = 1; drive(p); step();
    p = '0; p.ex_v = 1; p.ex_mr = 1; p.ex_rd = 7; p.id_v = 1; p.id_rs2 = 7;
    drive(p); #1;
    chk("lu_sif", stall_if_o, 1); chk("lu_sid", stall_id_o, 1);
    chk("lu_fex", flush_ex_o, 1); chk("lu_sex", stall_ex_o, 0);
    step();
    drive('0); #1;
    chk("lu_sif_after", stall_if_o, 0);
    chk("lu_cnt", stall_cycles_o, 1);
    step();

    // ---------------- branch ----------------
    p = '0; p.clr = 1; drive(p); step();
    p = '0; p.br = 1; p.tgt = 32'h0000_0100; drive(p); #1;
    chk("br_fid_N", flush_id_o, 1); chk("br_fex_N", flush_ex_o, 1);
    chk("br_rv_N", redirect_valid_o, 0);
    step();
    drive('0); #1;
    chk("br_fid_N1", flush_id_o, 1); chk("br_fex_N1", flush_ex_o, 1);
    chk("br_rv_N1", redirect_valid_o, 1); chk("br_pc_N1", redirect_pc_o, 32'h100);
    chk("br_fc", flush_count_o, 1);
    step();
    chk("br_rv_N2", redirect_valid_o, 0); chk("br_fid_N2", flush_id_o, 0);
    step();

    // ---------------- busy + branch overlap ----------------
    p = '0; p.clr = 1; drive(p); step();
    for (int k = 0; k < 3; k++) begin
      p = '0; p.busy = 1; p.br = 1; p.tgt = 32'h0000_0200; drive(p); #1;
      chk("bb_smem", stall_mem_o, 1); chk("bb_sif", stall_if_o, 1);
      chk("bb_fid", flush_id_o, 0); chk("bb_rv", redirect_valid_o, 0);
      step();
    end
    p.busy = 0; drive(p); #1;
    chk("bb_acc_fid", flush_id_o, 1); chk("bb_acc_sif", stall_if_o, 0);
    step();
    drive('0); #1;
    chk("bb_rv", redirect_valid_o, 1); chk("bb_pc", redirect_pc_o, 32'h200);
    chk("bb_sc", stall_cycles_o, 3); chk("bb_fc", flush_count_o, 1);
    step();

    // ---------------- counter wrap and clear ----------------
    p = '0; p.clr = 1; drive(p); step();
    p = '0; p.busy = 1; drive(p);
    for (int k = 0; k < 255; k++) step();
    chk("wrap_max", stall_cycles_o, 8'hFF);
    step();
    chk("wrap_zero", stall_cycles_o, 0);
    step();
    p.clr = 1; drive(p); step();
    chk("clr_vs_inc", stall_cycles_o, 0);
    drive('0); step();

    // ---------------- reset mid-FLUSH ----------------
    p = '0; p.br = 1; p.tgt = 32'h0000_0ABC; drive(p); step();
    #2; rst_ni = 0; #1;
    chk("mrst_rv", redirect_valid_o, 0);
    chk("mrst_pc", redirect_pc_o, 0);
    chk("mrst_sc", stall_cycles_o, 0);
    chk("mrst_fc", flush_count_o, 0);
    branch_taken_i = 0; #1;
    chk("mrst_state_run", flush_id_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1;
    model_reset();
    drive('0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("mrst_no_redir", redirect_valid_o, 0);
    end

    // ---------------- random ----------------
    for (int k = 0; k < 1500; k++) begin
      p.id_v   = 1'($urandom_range(0, 1));
      p.id_rs1 = RAW'($urandom_range(0, 7));
      p.id_rs2 = RAW'($urandom_range(0, 7));
      p.ex_v   = 1'($urandom_range(0, 1));
      p.ex_rs1 = RAW'($urandom_range(0, 7));
      p.ex_rs2 = RAW'($urandom_range(0, 7));
      p.ex_rd  = RAW'($urandom_range(0, 7));
      p.ex_rw  = 1'($urandom_range(0, 1));
      p.ex_mr  = 1'($urandom_range(0, 1));
      p.mem_v  = 1'($urandom_range(0, 1));
      p.mem_rd = RAW'($urandom_range(0, 7));
      p.mem_rw = 1'($urandom_range(0, 1));
      p.mem_mr = ($urandom_range(0, 3) == 0);
      p.wb_v   = 1'($urandom_range(0, 1));
      p.wb_rd  = RAW'($urandom_range(0, 7));
      p.wb_rw  = 1'($urandom_range(0, 1));
      p.br     = ($urandom_range(0, 4) == 0);
      p.tgt    = $urandom;
      p.busy   = ($urandom_range(0, 4) == 0);
      p.clr    = ($urandom_range(0, 19) == 0);
      drive(p);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
